piso_serializer: RTL and testbench
==================================

PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving parallel word width in bits; legal range 2..32.
REQ-002 The block SHALL have parameter LSB_FIRST, default 0; 0 = MSB shifted out first, 1 = LSB shifted out first.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset, with the clock port named clk and the reset port named rst_n.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 load_valid  input  1  parallel word on data is offered.
REQ-007 load_ready  output  1  block accepts a word this cycle.
REQ-008 data  input  WIDTH  parallel word; sampled only on accept.
REQ-009 shift_en  input  1  advance enable; 0 stalls the serial stream.
REQ-010 sout  output  1  serial data bit (registered).
REQ-011 sout_valid  output  1  sout carries a valid bit of the current frame.
REQ-012 last  output  1  sout carries the final bit of the frame.
REQ-013 busy  output  1  frame in progress (state SHIFT).

Function
REQ-014 The block SHALL implement two states: IDLE and SHIFT.
REQ-015 Accept SHALL occur on a rising edge where load_valid=1 and load_ready=1; data is then captured into the shift register and the bit counter is cleared to 0.
REQ-016 load_ready SHALL be combinational: 1 in IDLE; 1 in SHIFT only when counter = WIDTH-1 and shift_en=1 (back-to-back); 0 otherwise.
REQ-017 Accept from IDLE SHALL move the block to SHIFT; the first bit SHALL appear on sout with sout_valid=1 in the cycle immediately after the accepting edge (latency 1).
REQ-018 sout SHALL be the MSB of the shift register when LSB_FIRST=0 and the LSB when LSB_FIRST=1.
REQ-019 In SHIFT, on each rising edge with shift_en=1 the register SHALL shift by one toward the output end (zero fill) and the counter SHALL increment; with shift_en=0 register, counter, sout and all flags SHALL hold.
REQ-020 The counter SHALL be ceil(log2(WIDTH)) bits, count 0..WIDTH-1, and never wrap within a frame.
REQ-021 last SHALL equal sout_valid AND (counter = WIDTH-1).
REQ-022 On an edge with counter = WIDTH-1 and shift_en=1: if load_valid=1 the new word SHALL be loaded and state stays SHIFT with no gap in sout_valid; otherwise state SHALL return to IDLE and sout_valid falls.
REQ-023 load_valid during SHIFT with load_ready=0 SHALL be ignored; the in-flight frame SHALL be unaffected.
REQ-024 In IDLE, sout and sout_valid SHALL be 0; busy SHALL equal (state = SHIFT).

Reset
REQ-025 rst_n=0 SHALL immediately, without a clock, force state IDLE, shift register 0, counter 0, sout 0, sout_valid 0, last 0, busy 0; load_ready then reads 1.
REQ-026 Reset asserted mid-frame SHALL abort the frame; no remaining bits are emitted after release.
REQ-027 The first accept SHALL be possible on the first rising edge after rst_n deasserts.

Verification
REQ-028 WIDTH=8, LSB_FIRST=0, shift_en=1, load 8'h0F from IDLE -> sout 0,0,0,0,1,1,1,1 on 8 consecutive cycles starting one cycle after accept, last=1 on the 8th only, then sout_valid=0, busy=0.
REQ-029 WIDTH=8, LSB_FIRST=1, load 8'h0F -> sout 1,1,1,1,0,0,0,0; last on the 8th bit.
REQ-030 Stall: load 8'hA5 (MSB first), drop shift_en for 3 cycles while bit index 2 (value 1) is on sout -> sout holds 1 and counter holds for 3 cycles, last appears 3 cycles later than unstalled (11 cycles after accept).
REQ-031 Back-to-back: load_valid held with 8'h0F then 8'hF0 -> 16 contiguous valid bits 0000111111110000, sout_valid never drops, load_ready=1 only on the 8th-bit cycle.
REQ-032 Ignored load: offer 8'hFF at bit 3 of an 8'h0F frame -> load_ready=0, stream continues 0F unchanged; 8'hFF is accepted only when load_ready rises.
REQ-033 Reset mid-frame: assert rst_n=0 at bit 4 of 8'hA5 -> sout, sout_valid, last, busy read 0 before the next clk edge; after release, load 8'h0F is emitted correctly with no residue of 8'hA5.

Source files
------------

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in / serial-out shifter with valid/ready load handshake.
//   clk, rst_n        : rising-edge clock, asynchronous active-low reset
//   load_valid/ready  : word offer / accept (load_ready is combinational)
//   data [WIDTH-1:0]  : parallel word, captured on accept
//   shift_en          : advance enable; 0 freezes the stream
//   sout, sout_valid  : serial bit and its qualifier
//   last              : sout is the final bit of the frame
//   busy              : a frame is in progress
module piso_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned LSB_FIRST = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] data,
    input  logic             shift_en,
    output logic             sout,
    output logic             sout_valid,
    output logic             last,
    output logic             busy
);

    localparam int unsigned     CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_sreg;
    logic [WIDTH-1:0]   w_sreg_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_next;
    logic               w_shifting;
    logic               w_at_last;
    logic               w_out_bit;

    assign w_shifting = (r_state == S_SHIFT);
    assign w_at_last  = w_shifting && (r_cnt == CNT_LAST);

    // A new word can enter while idle, or on the edge that retires the last bit.
    assign load_ready = (r_state == S_IDLE) || (w_at_last && shift_en);

    // State, shift register and bit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_sreg  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_sreg  <= w_sreg_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        w_state_next = r_state;
        w_sreg_next  = r_sreg;
        w_cnt_next   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (load_valid) begin
                    w_state_next = S_SHIFT;
                    w_sreg_next  = data;
                    w_cnt_next   = '0;
                end
            end
            S_SHIFT: begin
                if (shift_en) begin
                    if (w_at_last) begin
                        if (load_valid) begin
                            w_sreg_next = data;
                            w_cnt_next  = '0;
                        end else begin
                            // Leave the register clean so idle output stays 0.
                            w_state_next = S_IDLE;
                            w_sreg_next  = '0;
                            w_cnt_next   = '0;
                        end
                    end else begin
                        if (LSB_FIRST != 0) begin
                            w_sreg_next = {1'b0, r_sreg[WIDTH-1:1]};
                        end else begin
                            w_sreg_next = {r_sreg[WIDTH-2:0], 1'b0};
                        end
                        w_cnt_next = r_cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_sreg_next  = '0;
                w_cnt_next   = '0;
            end
        endcase
    end

    assign w_out_bit  = (LSB_FIRST != 0) ? r_sreg[0] : r_sreg[WIDTH-1];

    // Outputs are decoded straight from flops.
    assign sout       = w_shifting && w_out_bit;
    assign sout_valid = w_shifting;
    assign busy       = w_shifting;
    assign last       = w_at_last;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench: two instances (MSB-first and LSB-first) share all inputs.
module tb_piso_serializer;

    logic       clk;
    logic       rst_n;
    logic       load_valid;
    logic [7:0] data;
    logic       shift_en;

    logic m_ready, m_sout, m_valid, m_last, m_busy;
    logic l_ready, l_sout, l_valid, l_last, l_busy;

    int checks;
    int errors;

    piso_serializer #(.WIDTH(8), .LSB_FIRST(0)) dut_m (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_ready (m_ready),
        .data       (data),
        .shift_en   (shift_en),
        .sout       (m_sout),
        .sout_valid (m_valid),
        .last       (m_last),
        .busy       (m_busy)
    );

    piso_serializer #(.WIDTH(8), .LSB_FIRST(1)) dut_l (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_ready (l_ready),
        .data       (data),
        .shift_en   (shift_en),
        .sout       (l_sout),
        .sout_valid (l_valid),
        .last       (l_last),
        .busy       (l_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Packs {sout, sout_valid, last, busy, load_ready} of the MSB-first instance.
    function automatic logic [31:0] m_outs();
        return {27'd0, m_sout, m_valid, m_last, m_busy, m_ready};
    endfunction

    function automatic logic [31:0] l_outs();
        return {27'd0, l_sout, l_valid, l_last, l_busy, l_ready};
    endfunction

    // Expected packed outputs during a frame bit.
    function automatic logic [31:0] in_frame(input logic b, input logic lst, input logic rdy);
        return {27'd0, b, 1'b1, lst, 1'b1, rdy};
    endfunction

    localparam logic [31:0] IDLE_OUTS = 32'h0000_0001;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] w;
        logic [7:0] w2;
        checks     = 0;
        errors     = 0;
        rst_n      = 1'b0;
        load_valid = 1'b0;
        data       = 8'h00;
        shift_en   = 1'b0;

        // Reset state
        #2;
        chk("reset_m", m_outs(), IDLE_OUTS);
        chk("reset_l", l_outs(), IDLE_OUTS);

        // Release reset and offer 0F so the first edge after release accepts.
        #10;
        rst_n      = 1'b1;
        load_valid = 1'b1;
        data       = 8'h0F;
        shift_en   = 1'b1;
        tick();
        load_valid = 1'b0;
        #1;
        // 0F: MSB-first 00001111, LSB-first 11110000
        w = 8'h0F;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("f0f_msb_bit%0d", i), m_outs(), in_frame(w[7-i], i == 7, i == 7));
            chk($sformatf("f0f_lsb_bit%0d", i), l_outs(), in_frame(w[i], i == 7, i == 7));
            tick();
        end
        chk("f0f_end_m", m_outs(), IDLE_OUTS);
        chk("f0f_end_l", l_outs(), IDLE_OUTS);

        // Stall: A5 = 1,0,1,0,0,1,0,1; hold 3 cycles with bit index 2 on sout.
        load_valid = 1'b1;
        data       = 8'hA5;
        tick();
        load_valid = 1'b0;
        data       = 8'h00;
        #1;
        w = 8'hA5;
        chk("stall_b0", m_outs(), in_frame(w[7], 1'b0, 1'b0));
        tick();
        chk("stall_b1", m_outs(), in_frame(w[6], 1'b0, 1'b0));
        tick();
        chk("stall_b2", m_outs(), in_frame(1'b1, 1'b0, 1'b0));
        shift_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("stall_hold%0d", i), m_outs(), in_frame(1'b1, 1'b0, 1'b0));
        end
        shift_en = 1'b1;
        #1;
        // Bits 3..7 follow; last shows up 10 edges after the accept edge.
        for (int i = 3; i < 8; i++) begin
            tick();
            chk($sformatf("stall_b%0d", i), m_outs(), in_frame(w[7-i], i == 7, i == 7));
        end
        tick();
        chk("stall_end", m_outs(), IDLE_OUTS);

        // Back-to-back 0F then F0 with load_valid held.
        load_valid = 1'b1;
        data       = 8'h0F;
        tick();
        data = 8'hF0;
        #1;
        w  = 8'h0F;
        w2 = 8'hF0;
        for (int j = 0; j < 16; j++) begin
            if (j < 8) begin
                chk($sformatf("b2b_bit%0d", j), m_outs(), in_frame(w[7-j], j == 7, j == 7));
            end else begin
                chk($sformatf("b2b_bit%0d", j), m_outs(), in_frame(w2[15-j], j == 15, j == 15));
            end
            tick();
            if (j == 7) begin
                load_valid = 1'b0;
                data       = 8'h00;
                #1;
            end
        end
        chk("b2b_end", m_outs(), IDLE_OUTS);

        // Ignored load: FF offered from bit 3 of a 0F frame.
        load_valid = 1'b1;
        data       = 8'h0F;
        tick();
        load_valid = 1'b0;
        #1;
        w = 8'h0F;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                load_valid = 1'b1;
                data       = 8'hFF;
                #1;
            end
            chk($sformatf("ign_bit%0d", i), m_outs(), in_frame(w[7-i], i == 7, i == 7));
            tick();
        end
        load_valid = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("ign_ff_bit%0d", i), m_outs(), in_frame(1'b1, i == 7, i == 7));
            tick();
        end
        chk("ign_end", m_outs(), IDLE_OUTS);

        // Reset mid-frame at bit 4 of A5, then a clean 0F frame.
        load_valid = 1'b1;
        data       = 8'hA5;
        tick();
        load_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        w = 8'hA5;
        chk("rst_pre_b4", m_outs(), in_frame(w[3], 1'b0, 1'b0));
        rst_n = 1'b0;
        #1;
        chk("rst_async_m", m_outs(), IDLE_OUTS);
        chk("rst_async_l", l_outs(), IDLE_OUTS);
        #1;
        rst_n = 1'b1;
        #1;
        chk("rst_released", m_outs(), IDLE_OUTS);
        load_valid = 1'b1;
        data       = 8'h0F;
        tick();
        load_valid = 1'b0;
        #1;
        w = 8'h0F;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("rst_f0f_bit%0d", i), m_outs(), in_frame(w[7-i], i == 7, i == 7));
            tick();
        end
        chk("rst_f0f_end", m_outs(), IDLE_OUTS);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
